fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the PC generator.
- Takes the current PC, runs a request/acknowledge read on instruction memory, and holds the returned 16-bit instruction plus its address for decode.
- Produces a one-cycle advance pulse when decode accepts an instruction. Top level ORs this pulse into the PC generator's write enable.
- A flush input drops any in-flight or held fetch on redirect (branch or PC write).

---
 rtl/fetch_unit_if.sv | 9 +
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_unit_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: req/ack instruction fetch holding one instruction for decode.
// Optional FETCH_TIMEOUT_EN adds an ack timeout with a sticky fetch_err flag.
module fetch_unit #(
    parameter logic [15:0] RESET_INST = 16'h0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] pc,
    input  logic        flush,
    fetch_unit_if.master imem,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    output logic        pc_wen,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FULL = 2'd2, DROP = 2'd3} state_t;
    state_t state;
    logic   expire;
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be in 1..255");
    end
    assign pc_wen = inst_valid & inst_ready & ~flush;
`ifdef FETCH_TIMEOUT_EN
    logic [7:0] cnt;
    // a flush that moves FETCH to DROP restarts the wait window instead of expiring
    assign expire = imem.req & ~imem.ack & ~(state == FETCH & flush) & (cnt == 8'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            if ((state == IDLE && !flush) || (state == FETCH && flush && !imem.ack)) cnt <= '0;
            else if (imem.req && !imem.ack) cnt <= cnt + 8'd1;
            if (expire) fetch_err <= 1'b1;
        end
`else
    assign expire    = 1'b0;
    assign fetch_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state      <= IDLE;
            imem.req   <= 1'b0;
            imem.addr  <= '0;
            inst_valid <= 1'b0;
            inst       <= RESET_INST;
            inst_pc    <= '0;
        end else
            case (state)
                IDLE:
                    if (!flush) begin
                        imem.addr <= pc;
                        imem.req  <= 1'b1;
                        state     <= FETCH;
                    end
                FETCH:
                    if (imem.ack) begin
                        imem.req <= 1'b0;
                        if (flush) state <= IDLE;
                        else begin
                            inst       <= imem.rdata;
                            inst_pc    <= imem.addr;
                            inst_valid <= 1'b1;
                            state      <= FULL;
                        end
                    end else if (flush) state <= DROP;
                    else if (expire) begin
                        imem.req <= 1'b0;
                        state    <= IDLE;
                    end
                DROP:
                    if (imem.ack || expire) begin
                        imem.req <= 1'b0;
                        state    <= IDLE;
                    end
                FULL:
                    // inst returns to RESET_INST whenever the slot empties
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        inst       <= RESET_INST;
                        state      <= IDLE;
                    end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against a
// transaction-level model (sequential PCs, redirect on flush, memory contents).
module tb_fetch_unit;
    localparam logic [15:0] RI = 16'h0013;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] pc = '0;
    logic        flush = 1'b0;
    logic        inst_ready = 1'b0;
    logic        inst_valid, pc_wen, fetch_err;
    logic [15:0] inst, inst_pc;
    fetch_unit_if bus();
    int checks = 0;
    int errors = 0;
    int n, last, accepted;
    logic [15:0] exp_pc, prev_addr;
    logic        prev_req;

    fetch_unit #(.RESET_INST(RI), .TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn), .pc(pc), .flush(flush), .imem(bus),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc_wen(pc_wen), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0] ^ 8'hC3, a[15:8] + 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; the PC generator advances on a pc_wen seen before the edge
    task automatic cyc();
        logic w;
        w = pc_wen;
        @(posedge clk);
        #2;
        if (w) pc = pc + 16'd2;
    endtask

    task automatic reset_seq(input logic [15:0] p);
        resetn   = 1'b0;
        flush    = 1'b0;
        bus.ack  = 1'b0;
        bus.rdata = '0;
        pc       = p;
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        bus.ack = 1'b0;
        bus.rdata = '0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_req", bus.req, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, RI);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_err", fetch_err, 0);

        // first fetch with two wait cycles
        inst_ready = 1'b1;
        reset_seq(16'h0000);
        cyc();
        chk("t1_req", bus.req, 1);
        chk("t1_addr", bus.addr, 16'h0000);
        cyc();
        cyc();
        bus.ack = 1'b1;
        bus.rdata = 16'hA5C3;
        cyc();
        bus.ack = 1'b0;
        chk("t1_valid", inst_valid, 1);
        chk("t1_inst", inst, 16'hA5C3);
        chk("t1_inst_pc", inst_pc, 16'h0000);
        #1 chk("t1_wen", pc_wen, 1);
        cyc();
        chk("t1_wen_off", pc_wen, 0);
        chk("t1_valid_off", inst_valid, 0);
        chk("t1_inst_idle", inst, RI);
        cyc();
        chk("t1_next_req", bus.req, 1);
        chk("t1_next_addr", bus.addr, 16'h0002);

        // zero-wait memory, four instructions
        reset_seq(16'h0000);
        n = 0;
        last = 0;
        exp_pc = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            bus.rdata = memf(bus.addr);
            bus.ack = 1'b1;
            #1;
            if (pc_wen) begin
                chk("t2_inst_pc", inst_pc, exp_pc);
                chk("t2_inst", inst, memf(exp_pc));
                if (n > 0) chk("t2_period", i - last, 3);
                last = i;
                n++;
                exp_pc = exp_pc + 16'd2;
            end
            cyc();
        end
        bus.ack = 1'b0;
        chk("t2_count", n, 4);

        // decode stalls five cycles
        inst_ready = 1'b0;
        reset_seq(16'h0020);
        cyc();
        bus.ack = 1'b1;
        bus.rdata = memf(bus.addr);
        cyc();
        bus.ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_valid", inst_valid, 1);
            chk("t3_inst", inst, memf(16'h0020));
            chk("t3_inst_pc", inst_pc, 16'h0020);
            chk("t3_wen", pc_wen, 0);
            chk("t3_req", bus.req, 0);
            cyc();
        end
        inst_ready = 1'b1;
        #1 chk("t3_wen_go", pc_wen, 1);
        cyc();
        chk("t3_valid_off", inst_valid, 0);
        cyc();
        chk("t3_addr_next", bus.addr, 16'h0022);

        // flush during FETCH; late ack is discarded
        reset_seq(16'h0010);
        cyc();
        chk("t4_req", bus.req, 1);
        chk("t4_addr", bus.addr, 16'h0010);
        flush = 1'b1;
        pc = 16'h0040;
        cyc();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t4_drop_req", bus.req, 1);
            chk("t4_drop_addr", bus.addr, 16'h0010);
            chk("t4_drop_valid", inst_valid, 0);
            cyc();
        end
        bus.ack = 1'b1;
        bus.rdata = 16'hDEAD;
        cyc();
        bus.ack = 1'b0;
        chk("t4_idle_req", bus.req, 0);
        chk("t4_idle_valid", inst_valid, 0);
        chk("t4_idle_inst", inst, RI);
        cyc();
        chk("t4_new_req", bus.req, 1);
        chk("t4_new_addr", bus.addr, 16'h0040);

        // flush and ready together in FULL
        bus.ack = 1'b1;
        bus.rdata = memf(16'h0040);
        cyc();
        bus.ack = 1'b0;
        chk("t5_valid", inst_valid, 1);
        chk("t5_inst", inst, memf(16'h0040));
        flush = 1'b1;
        #1 chk("t5_wen", pc_wen, 0);
        cyc();
        flush = 1'b0;
        chk("t5_valid_off", inst_valid, 0);
        chk("t5_inst_off", inst, RI);

        // asynchronous reset mid-FETCH
        cyc();
        chk("t6_req", bus.req, 1);
        resetn = 1'b0;
        #1;
        chk("t6_req_rst", bus.req, 0);
        chk("t6_addr_rst", bus.addr, 0);
        chk("t6_valid_rst", inst_valid, 0);
        chk("t6_inst_rst", inst, RI);
        chk("t6_inst_pc_rst", inst_pc, 0);
        chk("t6_err_rst", fetch_err, 0);

        // memory never acknowledges
        reset_seq(16'h0080);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("t7_wait_req", bus.req, 1);
            chk("t7_wait_err", fetch_err, 0);
            cyc();
        end
`ifdef FETCH_TIMEOUT_EN
        chk("t7_to_req", bus.req, 0);
        chk("t7_to_err", fetch_err, 1);
`else
        chk("t7_to_req", bus.req, 1);
        chk("t7_to_err", fetch_err, 0);
`endif
        cyc();
        chk("t7_retry_req", bus.req, 1);
        chk("t7_retry_addr", bus.addr, 16'h0080);
        bus.ack = 1'b1;
        bus.rdata = memf(16'h0080);
        cyc();
        bus.ack = 1'b0;
        chk("t7_valid", inst_valid, 1);
        chk("t7_inst", inst, memf(16'h0080));
`ifdef FETCH_TIMEOUT_EN
        chk("t7_err_sticky", fetch_err, 1);
`else
        chk("t7_err_zero", fetch_err, 0);
`endif

        // randomized traffic against the transaction model
        reset_seq(16'h0200);
        exp_pc = 16'h0200;
        accepted = 0;
        prev_req = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 600; i++) begin
            if (prev_req && bus.req) chk("r_addr_stable", bus.addr, prev_addr);
            prev_req = bus.req;
            prev_addr = bus.addr;
            flush = ($urandom_range(0, 15) == 0);
            if (flush) begin
                pc = 16'($urandom) & 16'hFFFE;
                exp_pc = pc;
            end
            inst_ready = $urandom_range(0, 1) == 1;
            if (bus.req) begin
                bus.ack = $urandom_range(0, 2) == 0;
                bus.rdata = memf(bus.addr);
            end else begin
                bus.ack = $urandom_range(0, 3) == 0;
                bus.rdata = 16'($urandom);
            end
            #1;
            chk("r_wen", pc_wen, inst_valid & inst_ready & ~flush);
            if (!inst_valid) chk("r_inst_idle", inst, RI);
            if (pc_wen) begin
                chk("r_inst_pc", inst_pc, exp_pc);
                chk("r_inst", inst, memf(exp_pc));
                exp_pc = exp_pc + 16'd2;
                accepted++;
            end
            cyc();
        end
        flush = 1'b0;
        bus.ack = 1'b0;
        chk("r_progress", accepted > 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
